// File: rtl/defs_pkg.sv
// Shared types for the multicycle control unit: state/opcode/condition encodings,
// ALU flag bundle and the datapath control bundle.
package defs_pkg;

  localparam int INSTRUCTION_WIDTH_DEF = 16;
  localparam int OPCODE_WIDTH_DEF      = 4;
  localparam int COND_WIDTH_DEF        = 3;
  localparam int STATE_WIDTH_DEF       = 5;
  localparam int MAX_WAIT_DEF          = 15;
  localparam int ALU_OP_WIDTH          = 3;

  typedef enum logic [4:0] {
    STATE_FETCH     = 5'd0,
    STATE_DECODE    = 5'd1,
    STATE_EXEC_ADDI = 5'd2,
    STATE_EXEC_ALU  = 5'd3,
    STATE_EXEC_LW   = 5'd4,
    STATE_EXEC_SW   = 5'd5,
    STATE_EXEC_LINK = 5'd6,
    STATE_EXEC_JMP  = 5'd7,
    STATE_EXEC_JPR  = 5'd8,
    STATE_EXEC_BRH  = 5'd9,
    STATE_MEM_LW    = 5'd10,
    STATE_MEM_SW    = 5'd11,
    STATE_WB_LI     = 5'd12,
    STATE_WB_ADDI   = 5'd13,
    STATE_WB_ALU    = 5'd14,
    STATE_WB_LW     = 5'd15,
    STATE_HALT      = 5'd16,
    STATE_TRAP      = 5'd17
  } state_t;

  // Codes 4'hA..4'hF are unassigned and trap.
  typedef enum logic [3:0] {
    OP_LI   = 4'h0,
    OP_ADDI = 4'h1,
    OP_LW   = 4'h2,
    OP_SW   = 4'h3,
    OP_ALU  = 4'h4,
    OP_JAL  = 4'h5,
    OP_JMP  = 4'h6,
    OP_JPR  = 4'h7,
    OP_BRH  = 4'h8,
    OP_HLT  = 4'h9
  } opcode_t;

  typedef enum logic [2:0] {
    COND_AL = 3'd0,
    COND_Z  = 3'd1,
    COND_NZ = 3'd2,
    COND_N  = 3'd3,
    COND_NN = 3'd4,
    COND_C  = 3'd5,
    COND_V  = 3'd6,
    COND_NV = 3'd7
  } cond_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

  localparam logic [1:0] PC_SRC_INC = 2'd0;
  localparam logic [1:0] PC_SRC_IMM = 2'd1;
  localparam logic [1:0] PC_SRC_REG = 2'd2;
  localparam logic [1:0] PC_SRC_REL = 2'd3;

  localparam logic [1:0] WSEL_IMM = 2'd0;
  localparam logic [1:0] WSEL_ALU = 2'd1;
  localparam logic [1:0] WSEL_MEM = 2'd2;
  localparam logic [1:0] WSEL_PC  = 2'd3;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD = '0;

  typedef struct packed {
    logic                    pc_we;
    logic [1:0]              pc_src;
    logic                    ir_we;
    logic                    mem_re;
    logic                    mem_we;
    logic                    mar_we;
    logic                    rf_re;
    logic                    rf_we;
    logic [1:0]              rf_wsel;
    logic                    alu_src_b;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic                    flags_we;
  } ctrl_sig_t;

  localparam ctrl_sig_t CTRL_DEFAULT = '0;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition decoder: condition code plus ALU flags -> taken.
module branch_cond_eval
  import defs_pkg::*;
(
  input  cond_t      cond,
  input  alu_flags_t flags,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_Z:  taken = flags.z;
      COND_NZ: taken = ~flags.z;
      COND_N:  taken = flags.n;
      COND_NN: taken = ~flags.n;
      COND_C:  taken = flags.c;
      COND_V:  taken = flags.v;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/exec/mem/writeback per opcode,
// with memory wait-state timeout, fetch-entry stall, HALT and trap states.
module multicycle_ctrl
  import defs_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = INSTRUCTION_WIDTH_DEF,
  parameter int OPCODE_WIDTH      = OPCODE_WIDTH_DEF,
  parameter int COND_WIDTH        = COND_WIDTH_DEF,
  parameter int STATE_WIDTH       = STATE_WIDTH_DEF,
  parameter int MAX_WAIT          = MAX_WAIT_DEF
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [INSTRUCTION_WIDTH-1:0] instr,
  input  alu_flags_t                   flags,
  input  logic                         mem_ready,
  input  logic                         stall,
  output ctrl_sig_t                    sigs,
  output logic [STATE_WIDTH-1:0]       state_o,
  output logic                         halted,
  output logic                         trap
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_t             y_q, y_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  ctrl_sig_t          sigs_c;
  logic               halted_c, trap_c;
  logic               taken;
  logic               wait_expired;
  opcode_t            opcode;
  cond_t              cond;

  assign opcode       = opcode_t'(instr[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH]);
  assign cond         = cond_t'(instr[INSTRUCTION_WIDTH-OPCODE_WIDTH-1 -: COND_WIDTH]);
  assign wait_expired = (wait_cnt_q == WAIT_W'(MAX_WAIT));

  branch_cond_eval u_cond (
    .cond  (cond),
    .flags (flags),
    .taken (taken)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      y_q        <= STATE_FETCH;
      wait_cnt_q <= '0;
    end else begin
      y_q        <= y_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    y_d        = STATE_FETCH;
    wait_cnt_d = '0;
    sigs_c     = CTRL_DEFAULT;
    halted_c   = 1'b0;
    trap_c     = 1'b0;
    case (y_q)
      STATE_FETCH: begin
        // A zero counter marks the entry cycle; once a request is pending, stall is ignored.
        if (stall && wait_cnt_q == '0) begin
          y_d = STATE_FETCH;
        end else begin
          sigs_c.mem_re = 1'b1;
          if (mem_ready) begin
            sigs_c.ir_we  = 1'b1;
            sigs_c.pc_we  = 1'b1;
            sigs_c.pc_src = PC_SRC_INC;
            y_d           = STATE_DECODE;
          end else if (wait_expired) begin
            y_d = STATE_TRAP;
          end else begin
            y_d        = STATE_FETCH;
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end
      end
      STATE_DECODE: begin
        sigs_c.rf_re = 1'b1;
        case (opcode)
          OP_LI:   y_d = STATE_WB_LI;
          OP_ADDI: y_d = STATE_EXEC_ADDI;
          OP_LW:   y_d = STATE_EXEC_LW;
          OP_SW:   y_d = STATE_EXEC_SW;
          OP_ALU:  y_d = STATE_EXEC_ALU;
          OP_JAL:  y_d = STATE_EXEC_LINK;
          OP_JMP:  y_d = STATE_EXEC_JMP;
          OP_JPR:  y_d = STATE_EXEC_JPR;
          OP_BRH:  y_d = STATE_EXEC_BRH;
          OP_HLT:  y_d = STATE_HALT;
          default: y_d = STATE_TRAP;
        endcase
      end
      STATE_EXEC_ADDI: begin
        sigs_c.alu_src_b = 1'b1;
        sigs_c.alu_op    = ALU_OP_ADD;
        y_d              = STATE_WB_ADDI;
      end
      STATE_EXEC_ALU: begin
        sigs_c.alu_src_b = 1'b0;
        sigs_c.alu_op    = instr[ALU_OP_WIDTH-1:0];
        sigs_c.flags_we  = 1'b1;
        y_d              = STATE_WB_ALU;
      end
      STATE_EXEC_LW, STATE_EXEC_SW: begin
        sigs_c.alu_src_b = 1'b1;
        sigs_c.alu_op    = ALU_OP_ADD;
        sigs_c.mar_we    = 1'b1;
        y_d              = (y_q == STATE_EXEC_LW) ? STATE_MEM_LW : STATE_MEM_SW;
      end
      STATE_MEM_LW, STATE_MEM_SW: begin
        sigs_c.mem_re = (y_q == STATE_MEM_LW);
        sigs_c.mem_we = (y_q == STATE_MEM_SW);
        if (mem_ready) begin
          y_d = (y_q == STATE_MEM_LW) ? STATE_WB_LW : STATE_FETCH;
        end else if (wait_expired) begin
          y_d = STATE_TRAP;
        end else begin
          y_d        = y_q;
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      STATE_EXEC_LINK: begin
        sigs_c.rf_we   = 1'b1;
        sigs_c.rf_wsel = WSEL_PC;
        sigs_c.pc_we   = 1'b1;
        sigs_c.pc_src  = PC_SRC_IMM;
      end
      STATE_EXEC_JMP: begin
        sigs_c.pc_we  = 1'b1;
        sigs_c.pc_src = PC_SRC_IMM;
      end
      STATE_EXEC_JPR: begin
        sigs_c.pc_we  = 1'b1;
        sigs_c.pc_src = PC_SRC_REG;
      end
      STATE_EXEC_BRH: begin
        sigs_c.pc_we  = taken;
        sigs_c.pc_src = PC_SRC_REL;
      end
      STATE_WB_LI: begin
        sigs_c.rf_we   = 1'b1;
        sigs_c.rf_wsel = WSEL_IMM;
      end
      STATE_WB_ADDI, STATE_WB_ALU: begin
        sigs_c.rf_we   = 1'b1;
        sigs_c.rf_wsel = WSEL_ALU;
      end
      STATE_WB_LW: begin
        sigs_c.rf_we   = 1'b1;
        sigs_c.rf_wsel = WSEL_MEM;
      end
      STATE_HALT: begin
        halted_c = 1'b1;
        y_d      = STATE_HALT;
      end
      STATE_TRAP: begin
        trap_c = 1'b1;
        y_d    = STATE_TRAP;
      end
      default: y_d = STATE_FETCH;
    endcase
  end

  // Outputs are forced quiet while reset is held so an aborted access drops immediately.
  assign sigs    = resetn ? sigs_c : CTRL_DEFAULT;
  assign halted  = halted_c;
  assign trap    = trap_c;
  assign state_o = STATE_WIDTH'(y_q);

endmodule
